cmdin_subqueue_dispatcher: RTL and testbench

Parametrised command-in dispatcher for the OmpSs manager. It scans the per-accelerator command subqueues held in the CmdIn BRAM in round-robin order and streams each valid command (header plus payload) to its accelerator over AXI-Stream. It then releases the slot back to the host. Each accelerator has a credit counter, so up to MAX_PENDING commands may be outstanding per accelerator; completions returning on cmdout_in restore the credits.

---
 rtl/cmdin_subqueue_dispatcher_pkg.sv | 27 ++
 rtl/cmdin_subqueue_dispatcher_credit.sv | 57 +++++
 rtl/cmdin_subqueue_dispatcher.sv | 184 ++++++++++++++++++
 tb/tb_cmdin_subqueue_dispatcher.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmdin_subqueue_dispatcher_pkg.sv
// Shared definitions for the command-in dispatcher: header field layout,
// the valid-byte marker and the dispatcher state encoding.
package cmdin_dispatch_pkg;

  localparam int HDR_VALID_LSB = 0;
  localparam int HDR_LEN_LSB   = 8;
  localparam int HDR_FIELD_W   = 8;

  localparam logic [HDR_FIELD_W-1:0] VALID_BYTE = 8'h80;

  typedef enum logic [2:0] {
    SCAN  = 3'd0,
    HDR   = 3'd1,
    SEND  = 3'd2,
    WAIT  = 3'd3,
    CLEAR = 3'd4
  } state_t;

  function automatic logic hdr_is_valid(input logic [63:0] word);
    return word[HDR_VALID_LSB +: HDR_FIELD_W] == VALID_BYTE;
  endfunction

  function automatic logic [HDR_FIELD_W-1:0] hdr_len(input logic [63:0] word);
    return word[HDR_LEN_LSB +: HDR_FIELD_W];
  endfunction

endpackage

// File: rtl/cmdin_subqueue_dispatcher_credit.sv
// Per-accelerator credit counters: completions add a credit, a finished
// dispatch removes one, and nonzero tells the scanner who may be served.
module acc_credit_bank #(
  parameter int MAX_ACCS    = 16,
  parameter int MAX_PENDING = 1,
  localparam int ACC_BITS   = $clog2(MAX_ACCS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inc_valid,
  input  logic [ACC_BITS-1:0] inc_id,
  input  logic                dec_valid,
  input  logic [ACC_BITS-1:0] dec_id,
  output logic [MAX_ACCS-1:0] nonzero,
  output logic                underflow
);

  localparam int CW = $clog2(MAX_PENDING + 1);
  localparam logic [CW-1:0] FULL    = CW'(MAX_PENDING);
  localparam logic [CW-1:0] CRD_ONE = CW'(1);

  logic [CW-1:0]       credit [MAX_ACCS];
  logic                inc_in_range;
  logic [MAX_ACCS-1:0] inc_sel;
  logic [MAX_ACCS-1:0] dec_sel;
  logic [MAX_ACCS-1:0] full_vec;

  assign inc_in_range = inc_valid && (32'(inc_id) < 32'(MAX_ACCS));

  always_comb begin
    for (int i = 0; i < MAX_ACCS; i++) begin
      full_vec[i] = (credit[i] == FULL);
      nonzero[i]  = (credit[i] != '0);
      inc_sel[i]  = inc_in_range && (inc_id == ACC_BITS'(i));
      dec_sel[i]  = dec_valid && (dec_id == ACC_BITS'(i));
    end
  end

  // A completion on a full counter is rejected and flagged; a rejected
  // completion does not cancel a same-cycle dispatch decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_ACCS; i++) credit[i] <= FULL;
      underflow <= 1'b0;
    end else begin
      underflow <= |(inc_sel & full_vec);
      for (int i = 0; i < MAX_ACCS; i++) begin
        if (inc_sel[i] && !full_vec[i] && !dec_sel[i]) begin
          credit[i] <= credit[i] + CRD_ONE;
        end else if (dec_sel[i] && !(inc_sel[i] && !full_vec[i]) && nonzero[i]) begin
          credit[i] <= credit[i] - CRD_ONE;
        end
      end
    end
  end

endmodule

// File: rtl/cmdin_subqueue_dispatcher.sv
// Round-robin dispatcher that streams commands out of the CmdIn BRAM
// subqueues to accelerators and hands each slot back to the host.
module cmdin_subqueue_dispatcher
  import cmdin_dispatch_pkg::*;
#(
  parameter int MAX_ACCS     = 16,
  parameter int SUBQUEUE_LEN = 64,
  parameter int MAX_PENDING  = 1,
  localparam int ACC_BITS    = $clog2(MAX_ACCS)
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                enable,
  output logic                cmdin_out_tvalid,
  input  logic                cmdin_out_tready,
  output logic [ACC_BITS-1:0] cmdin_out_tdest,
  output logic [63:0]         cmdin_out_tdata,
  output logic                cmdin_out_tlast,
  input  logic                cmdout_in_tvalid,
  output logic                cmdout_in_tready,
  input  logic [ACC_BITS-1:0] cmdout_in_tid,
  input  logic [63:0]         cmdout_in_tdata,
  output logic                cmdin_queue_clk,
  output logic                cmdin_queue_rst,
  output logic                cmdin_queue_en,
  output logic [7:0]          cmdin_queue_we,
  output logic [31:0]         cmdin_queue_addr,
  output logic [63:0]         cmdin_queue_din,
  input  logic [63:0]         cmdin_queue_dout,
  output logic                err_malformed,
  output logic                err_underflow
);

  localparam int SQ_BITS  = $clog2(SUBQUEUE_LEN);
  localparam int IDX_BITS = ACC_BITS + SQ_BITS;
  localparam logic [SQ_BITS-1:0]  SQ_ONE  = SQ_BITS'(1);
  localparam logic [ACC_BITS-1:0] ACC_ONE = ACC_BITS'(1);
  localparam logic [ACC_BITS-1:0] ACC_MAX = ACC_BITS'(MAX_ACCS - 1);

  state_t              state;
  logic [ACC_BITS-1:0] rr;
  logic [ACC_BITS-1:0] rr_next;
  logic [SQ_BITS-1:0]  rd_ptr [MAX_ACCS];
  logic [SQ_BITS-1:0]  pay_ptr;
  logic [SQ_BITS-1:0]  adv_len;
  logic [7:0]          remain;
  logic [MAX_ACCS-1:0] nonzero;
  logic                eligible;
  logic                handshake;
  logic                hdr_valid;
  logic [7:0]          hdr_n;
  logic                hdr_too_long;
  logic [IDX_BITS-1:0] word_idx;
  logic                credit_dec;
  logic                unused_cmdout_data;

  assign cmdin_queue_clk    = aclk;
  assign cmdin_queue_rst    = ~aresetn;
  assign cmdin_queue_din    = '0;
  assign unused_cmdout_data = ^cmdout_in_tdata;

  assign rr_next      = (rr == ACC_MAX) ? '0 : rr + ACC_ONE;
  assign eligible     = enable && nonzero[rr];
  assign handshake    = cmdin_out_tvalid && cmdin_out_tready;
  assign hdr_valid    = hdr_is_valid(cmdin_queue_dout);
  assign hdr_n        = hdr_len(cmdin_queue_dout);
  assign hdr_too_long = 32'(hdr_n) > 32'(SUBQUEUE_LEN - 1);

  // err_malformed is high for exactly the CLEAR cycle of a malformed
  // header, so it doubles as the "do not consume a credit" qualifier.
  assign credit_dec = (state == CLEAR) && !err_malformed;

  // The BRAM port is driven from the current state so read data lands in
  // the very next cycle, giving one stream word every two cycles.
  always_comb begin
    cmdin_queue_en = 1'b0;
    cmdin_queue_we = 8'h00;
    word_idx       = {rr, rd_ptr[rr]};
    case (state)
      SCAN:  cmdin_queue_en = eligible;
      SEND: begin
        if (handshake && !cmdin_out_tlast) begin
          cmdin_queue_en = 1'b1;
          word_idx       = {rr, pay_ptr};
        end
      end
      CLEAR: begin
        cmdin_queue_en = 1'b1;
        cmdin_queue_we = 8'h01;
      end
      default: ;
    endcase
    if (!aresetn) begin
      cmdin_queue_en = 1'b0;
      cmdin_queue_we = 8'h00;
    end
  end

  assign cmdin_queue_addr = 32'({word_idx, 3'b000});

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state            <= SCAN;
      rr               <= '0;
      for (int i = 0; i < MAX_ACCS; i++) rd_ptr[i] <= '0;
      pay_ptr          <= '0;
      adv_len          <= '0;
      remain           <= '0;
      cmdin_out_tvalid <= 1'b0;
      cmdin_out_tdest  <= '0;
      cmdin_out_tdata  <= '0;
      cmdin_out_tlast  <= 1'b0;
      err_malformed    <= 1'b0;
      cmdout_in_tready <= 1'b0;
    end else begin
      cmdout_in_tready <= 1'b1;
      err_malformed    <= 1'b0;
      case (state)
        SCAN: begin
          if (eligible) state <= HDR;
          else          rr    <= rr_next;
        end
        HDR: begin
          if (!hdr_valid) begin
            rr    <= rr_next;
            state <= SCAN;
          end else if (hdr_too_long) begin
            err_malformed <= 1'b1;
            adv_len       <= '0;
            state         <= CLEAR;
          end else begin
            cmdin_out_tdata  <= cmdin_queue_dout;
            cmdin_out_tdest  <= rr;
            cmdin_out_tlast  <= (hdr_n == 8'd0);
            cmdin_out_tvalid <= 1'b1;
            remain           <= hdr_n;
            adv_len          <= SQ_BITS'(hdr_n);
            pay_ptr          <= rd_ptr[rr] + SQ_ONE;
            state            <= SEND;
          end
        end
        SEND: begin
          if (handshake) begin
            cmdin_out_tvalid <= 1'b0;
            if (cmdin_out_tlast) begin
              state <= CLEAR;
            end else begin
              pay_ptr <= pay_ptr + SQ_ONE;
              remain  <= remain - 8'd1;
              state   <= WAIT;
            end
          end
        end
        WAIT: begin
          cmdin_out_tdata  <= cmdin_queue_dout;
          cmdin_out_tlast  <= (remain == 8'd0);
          cmdin_out_tvalid <= 1'b1;
          state            <= SEND;
        end
        CLEAR: begin
          rd_ptr[rr] <= rd_ptr[rr] + adv_len + SQ_ONE;
          rr         <= rr_next;
          state      <= SCAN;
        end
        default: state <= SCAN;
      endcase
    end
  end

  acc_credit_bank #(
    .MAX_ACCS    (MAX_ACCS),
    .MAX_PENDING (MAX_PENDING)
  ) u_credit (
    .clk       (aclk),
    .rst_n     (aresetn),
    .inc_valid (cmdout_in_tvalid && cmdout_in_tready),
    .inc_id    (cmdout_in_tid),
    .dec_valid (credit_dec),
    .dec_id    (rr),
    .nonzero   (nonzero),
    .underflow (err_underflow)
  );

endmodule

// File: tb/tb_cmdin_subqueue_dispatcher.sv
// Directed bench for the command-in dispatcher with a behavioural BRAM,
// a stream monitor and an expected-beat scoreboard.
module tb_cmdin_subqueue_dispatcher;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        enable = 1'b0;
  logic        cmdin_out_tvalid;
  logic        cmdin_out_tready = 1'b0;
  logic [3:0]  cmdin_out_tdest;
  logic [63:0] cmdin_out_tdata;
  logic        cmdin_out_tlast;
  logic        cmdout_in_tvalid = 1'b0;
  logic        cmdout_in_tready;
  logic [3:0]  cmdout_in_tid = 4'd0;
  logic [63:0] cmdout_in_tdata = 64'd0;
  logic        cmdin_queue_clk;
  logic        cmdin_queue_rst;
  logic        cmdin_queue_en;
  logic [7:0]  cmdin_queue_we;
  logic [31:0] cmdin_queue_addr;
  logic [63:0] cmdin_queue_din;
  logic [63:0] cmdin_queue_dout = 64'd0;
  logic        err_malformed;
  logic        err_underflow;

  cmdin_subqueue_dispatcher dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .enable           (enable),
    .cmdin_out_tvalid (cmdin_out_tvalid),
    .cmdin_out_tready (cmdin_out_tready),
    .cmdin_out_tdest  (cmdin_out_tdest),
    .cmdin_out_tdata  (cmdin_out_tdata),
    .cmdin_out_tlast  (cmdin_out_tlast),
    .cmdout_in_tvalid (cmdout_in_tvalid),
    .cmdout_in_tready (cmdout_in_tready),
    .cmdout_in_tid    (cmdout_in_tid),
    .cmdout_in_tdata  (cmdout_in_tdata),
    .cmdin_queue_clk  (cmdin_queue_clk),
    .cmdin_queue_rst  (cmdin_queue_rst),
    .cmdin_queue_en   (cmdin_queue_en),
    .cmdin_queue_we   (cmdin_queue_we),
    .cmdin_queue_addr (cmdin_queue_addr),
    .cmdin_queue_din  (cmdin_queue_din),
    .cmdin_queue_dout (cmdin_queue_dout),
    .err_malformed    (err_malformed),
    .err_underflow    (err_underflow)
  );

  // ---------------- clock ----------------
  always #5 aclk = ~aclk;

  // ---------------- BRAM model (16 subqueues x 64 words) ----------------
  logic [63:0] mem [0:1023];
  int          wr_cnt = 0;
  logic [31:0] last_wr_addr = 32'd0;
  logic [7:0]  last_wr_we = 8'd0;
  logic [63:0] last_wr_din = 64'd0;

  always @(posedge aclk) begin
    if (cmdin_queue_en) begin
      if (cmdin_queue_we != 8'h00) begin
        for (int b = 0; b < 8; b++)
          if (cmdin_queue_we[b]) mem[cmdin_queue_addr[12:3]][b*8 +: 8] <= cmdin_queue_din[b*8 +: 8];
        wr_cnt++;
        last_wr_addr = cmdin_queue_addr;
        last_wr_we   = cmdin_queue_we;
        last_wr_din  = cmdin_queue_din;
      end
      cmdin_queue_dout <= mem[cmdin_queue_addr[12:3]];
    end
  end

  // ---------------- stream monitor ----------------
  logic [63:0] got_data_q[$];
  logic [3:0]  got_dest_q[$];
  logic        got_last_q[$];
  int          stall_viol = 0;
  int          stall_cnt = 0;
  int          malformed_cnt = 0;
  int          underflow_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data = 64'd0;
  logic [3:0]  prev_dest = 4'd0;
  logic        prev_last = 1'b0;

  always @(negedge aclk) begin
    if (aresetn) begin
      if (prev_stall && cmdin_out_tvalid &&
          (cmdin_out_tdata !== prev_data || cmdin_out_tdest !== prev_dest || cmdin_out_tlast !== prev_last))
        stall_viol++;
      if (cmdin_out_tvalid && cmdin_out_tready) begin
        got_data_q.push_back(cmdin_out_tdata);
        got_dest_q.push_back(cmdin_out_tdest);
        got_last_q.push_back(cmdin_out_tlast);
      end
      if (cmdin_out_tvalid && !cmdin_out_tready) stall_cnt++;
      prev_stall = cmdin_out_tvalid && !cmdin_out_tready;
      prev_data  = cmdin_out_tdata;
      prev_dest  = cmdin_out_tdest;
      prev_last  = cmdin_out_tlast;
      if (err_malformed) malformed_cnt++;
      if (err_underflow) underflow_cnt++;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  logic [3:0]  exp_dest_q[$];
  logic        exp_last_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] d, input logic [3:0] dest, input logic last);
    exp_q.push_back(d);
    exp_dest_q.push_back(dest);
    exp_last_q.push_back(last);
  endtask

  task automatic cmp_beats(input string tag);
    int k;
    logic [63:0] ed, gd;
    logic [3:0]  edst, gdst;
    logic        el, gl;
    k = 0;
    check($sformatf("%s count", tag), 64'(got_data_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && got_data_q.size() > 0) begin
      ed = exp_q.pop_front();      gd = got_data_q.pop_front();
      edst = exp_dest_q.pop_front(); gdst = got_dest_q.pop_front();
      el = exp_last_q.pop_front(); gl = got_last_q.pop_front();
      check($sformatf("%s[%0d] data", tag, k), gd, ed);
      check($sformatf("%s[%0d] dest", tag, k), 64'(gdst), 64'(edst));
      check($sformatf("%s[%0d] last", tag, k), 64'(gl), 64'(el));
      k++;
    end
    exp_q.delete(); exp_dest_q.delete(); exp_last_q.delete();
    got_data_q.delete(); got_dest_q.delete(); got_last_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic wait_beats(input int n, input int budget, input string tag);
    int c;
    c = 0;
    while (got_data_q.size() < n && c < budget) begin
      @(posedge aclk); #1;
      c++;
    end
    check($sformatf("%s beats arrived", tag), 64'(got_data_q.size() >= n), 64'd1);
  endtask

  task automatic complete(input logic [3:0] id);
    @(posedge aclk); #1;
    cmdout_in_tvalid = 1'b1;
    cmdout_in_tid    = id;
    @(posedge aclk); #1;
    cmdout_in_tvalid = 1'b0;
  endtask

  function automatic int widx(input int acc, input int slot);
    return acc * 64 + slot;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int c;
    for (int i = 0; i < 1024; i++) mem[i] = 64'd0;

    // Reset state
    cycles(3);
    check("rst tvalid", 64'(cmdin_out_tvalid), 64'd0);
    check("rst tdata", cmdin_out_tdata, 64'd0);
    check("rst queue_rst", 64'(cmdin_queue_rst), 64'd1);
    check("rst queue_en", 64'(cmdin_queue_en), 64'd0);
    check("rst cmdout_tready", 64'(cmdout_in_tready), 64'd0);

    // Round-robin order 0,1,5 plus a malformed header on acc 8
    mem[widx(0, 0)] = 64'hC000_0000_0000_0080;
    mem[widx(1, 0)] = 64'hC100_0000_0000_0080;
    mem[widx(5, 0)] = 64'hC500_0000_0000_0080;
    mem[widx(8, 0)] = 64'h0000_0000_0000_4080;
    mem[widx(8, 1)] = 64'hC800_0000_0000_0080;
    enable = 1'b1;
    cmdin_out_tready = 1'b1;
    aresetn = 1'b1;
    cycles(1);
    check("cmdout_tready after reset", 64'(cmdout_in_tready), 64'd1);
    push_exp(64'hC000_0000_0000_0080, 4'd0, 1'b1);
    push_exp(64'hC100_0000_0000_0080, 4'd1, 1'b1);
    push_exp(64'hC500_0000_0000_0080, 4'd5, 1'b1);
    push_exp(64'hC800_0000_0000_0080, 4'd8, 1'b1);
    wait_beats(4, 300, "order");
    cycles(4);
    cmp_beats("order");
    check("malformed pulses", 64'(malformed_cnt), 64'd1);
    check("malformed slot cleared", mem[widx(8, 0)], 64'h0000_0000_0000_4000);
    check("acc5 slot cleared", mem[widx(5, 0)], 64'hC500_0000_0000_0000);

    // acc 3: 3-beat command, then a second one gated by credit
    mem[widx(3, 0)] = 64'h0000_0000_0000_0280;
    mem[widx(3, 1)] = 64'h0000_0000_0000_00A1;
    mem[widx(3, 2)] = 64'h0000_0000_0000_00A2;
    mem[widx(3, 3)] = 64'h1234_0000_0000_0080;
    push_exp(64'h0000_0000_0000_0280, 4'd3, 1'b0);
    push_exp(64'h0000_0000_0000_00A1, 4'd3, 1'b0);
    push_exp(64'h0000_0000_0000_00A2, 4'd3, 1'b1);
    wait_beats(3, 200, "acc3");
    cycles(5);
    cmp_beats("acc3");
    check("acc3 clear addr", 64'(last_wr_addr), 64'd1536);
    check("acc3 clear we", 64'(last_wr_we), 64'h01);
    check("acc3 clear din", last_wr_din, 64'd0);
    check("acc3 header valid byte cleared", mem[widx(3, 0)], 64'h0000_0000_0000_0200);
    cycles(100);
    check("acc3 held without credit", 64'(got_data_q.size()), 64'd0);
    complete(4'd3);
    push_exp(64'h1234_0000_0000_0080, 4'd3, 1'b1);
    wait_beats(1, 60, "acc3 second");
    cycles(4);
    cmp_beats("acc3 second");

    // Underflow: first completion restores the credit, second overflows it
    complete(4'd3);
    cycles(3);
    check("no underflow on valid completion", 64'(underflow_cnt), 64'd0);
    complete(4'd3);
    cycles(3);
    check("underflow pulse", 64'(underflow_cnt), 64'd1);

    // enable=0 holds off new commands
    enable = 1'b0;
    cycles(6);
    mem[widx(2, 0)] = 64'h2200_0000_0000_0080;
    cycles(60);
    check("disabled idle", 64'(got_data_q.size()), 64'd0);
    enable = 1'b1;
    push_exp(64'h2200_0000_0000_0080, 4'd2, 1'b1);
    wait_beats(1, 100, "enable");
    cycles(4);
    cmp_beats("enable");

    // acc 4: long command to move rd_ptr to 62, then a wrapping command
    mem[widx(4, 0)] = 64'h0000_0000_0000_3D80;
    push_exp(64'h0000_0000_0000_3D80, 4'd4, 1'b0);
    for (int k = 1; k <= 61; k++) begin
      mem[widx(4, k)] = 64'hB000_0000_0000_0000 + 64'(k);
      push_exp(64'hB000_0000_0000_0000 + 64'(k), 4'd4, k == 61);
    end
    mem[widx(4, 62)] = 64'hD000_0000_0000_0280;
    mem[widx(4, 63)] = 64'hE000_0000_0000_0063;
    wait_beats(62, 400, "long");
    cycles(4);
    cmp_beats("long");
    mem[widx(4, 0)] = 64'hE000_0000_0000_0000;
    complete(4'd4);
    push_exp(64'hD000_0000_0000_0280, 4'd4, 1'b0);
    push_exp(64'hE000_0000_0000_0063, 4'd4, 1'b0);
    push_exp(64'hE000_0000_0000_0000, 4'd4, 1'b1);
    wait_beats(3, 100, "wrap");
    cycles(4);
    cmp_beats("wrap");
    mem[widx(4, 1)] = 64'hF100_0000_0000_0080;
    complete(4'd4);
    push_exp(64'hF100_0000_0000_0080, 4'd4, 1'b1);
    wait_beats(1, 100, "after wrap");
    cycles(4);
    cmp_beats("after wrap");

    // acc 6: 4-word command with tready toggling every cycle
    cmdin_out_tready = 1'b0;
    mem[widx(6, 0)] = 64'h6600_0000_0000_0380;
    mem[widx(6, 1)] = 64'h6000_0000_0000_00A1;
    mem[widx(6, 2)] = 64'h6000_0000_0000_00A2;
    mem[widx(6, 3)] = 64'h6000_0000_0000_00A3;
    push_exp(64'h6600_0000_0000_0380, 4'd6, 1'b0);
    push_exp(64'h6000_0000_0000_00A1, 4'd6, 1'b0);
    push_exp(64'h6000_0000_0000_00A2, 4'd6, 1'b0);
    push_exp(64'h6000_0000_0000_00A3, 4'd6, 1'b1);
    stall_cnt = 0;
    c = 0;
    while (got_data_q.size() < 4 && c < 200) begin
      @(posedge aclk); #1;
      cmdin_out_tready = ~cmdin_out_tready;
      c++;
    end
    cmdin_out_tready = 1'b1;
    cycles(4);
    cmp_beats("toggle");
    check("stall stability", 64'(stall_viol), 64'd0);
    check("stalls exercised", 64'(stall_cnt != 0), 64'd1);

    // Reset in the middle of SEND
    mem[widx(4, 0)] = 64'hA400_0000_0000_0080;
    mem[widx(7, 0)] = 64'h7700_0000_0000_0380;
    mem[widx(7, 1)] = 64'h7000_0000_0000_0071;
    mem[widx(7, 2)] = 64'h7000_0000_0000_0072;
    mem[widx(7, 3)] = 64'h7000_0000_0000_0073;
    cmdin_out_tready = 1'b0;
    c = 0;
    while (!cmdin_out_tvalid && c < 100) begin
      @(negedge aclk);
      c++;
    end
    check("acc7 tvalid before reset", 64'(cmdin_out_tvalid), 64'd1);
    check("acc7 header held", cmdin_out_tdata, 64'h7700_0000_0000_0380);
    check("acc7 dest held", 64'(cmdin_out_tdest), 64'd7);
    aresetn = 1'b0;
    #1;
    check("reset drops tvalid", 64'(cmdin_out_tvalid), 64'd0);
    check("reset clears tlast", 64'(cmdin_out_tlast), 64'd0);
    cycles(3);
    aresetn = 1'b1;
    cmdin_out_tready = 1'b1;
    push_exp(64'hA400_0000_0000_0080, 4'd4, 1'b1);
    push_exp(64'h7700_0000_0000_0380, 4'd7, 1'b0);
    push_exp(64'h7000_0000_0000_0071, 4'd7, 1'b0);
    push_exp(64'h7000_0000_0000_0072, 4'd7, 1'b0);
    push_exp(64'h7000_0000_0000_0073, 4'd7, 1'b1);
    wait_beats(5, 200, "post reset");
    cycles(4);
    cmp_beats("post reset");
    check("no stray malformed", 64'(malformed_cnt), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
